// File: rtl/life_generation_engine_if.sv
// life_generation_engine_if: row bus between the generation engine and its two line-buffer banks.
// Signals (master = engine side, slave = bank/memory side):
//   line_buffer_fetch_addr          row address into the current read bank
//   line_buffer_fetch_mem           row data returned READ_LATENCY cycles after the address
//   parallel_next_state_write_addr  destination row in the write bank
//   parallel_next_state_result      next-state row
//   parallel_next_state_write_en    one-cycle write strobe per row
interface life_generation_engine_if #(
    parameter int X_SIZE  = 1280,
    parameter int Y_WIDTH = 10
);
    logic [Y_WIDTH-1:0] line_buffer_fetch_addr;
    logic [X_SIZE-1:0]  line_buffer_fetch_mem;
    logic [Y_WIDTH-1:0] parallel_next_state_write_addr;
    logic [X_SIZE-1:0]  parallel_next_state_result;
    logic               parallel_next_state_write_en;
    modport master (
        output line_buffer_fetch_addr,
        input  line_buffer_fetch_mem,
        output parallel_next_state_write_addr,
        output parallel_next_state_result,
        output parallel_next_state_write_en
    );
    modport slave (
        input  line_buffer_fetch_addr,
        output line_buffer_fetch_mem,
        input  parallel_next_state_write_addr,
        input  parallel_next_state_result,
        input  parallel_next_state_write_en
    );
endinterface

// File: rtl/life_generation_engine.sv
// life_generation_engine: computes one toroidal Game-of-Life generation per accepted trigger.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   frame_tick        frame-boundary pulse; starts a generation when not paused
//   pause, step       hold generations; step runs exactly one while paused
//   bus               row fetch / row write bus (master side)
//   mode              bank select, 1 = A read/B write, 0 = B read/A write
//   busy, gen_done    generation in progress, one-cycle completion pulse
//   generation_count  completed generations, wrapping
module life_generation_engine #(
    parameter int X_SIZE       = 1280,
    parameter int Y_SIZE       = 720,
    parameter int X_WIDTH      = 11,
    parameter int Y_WIDTH      = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            frame_tick,
    input  logic                            pause,
    input  logic                            step,
    life_generation_engine_if.master        bus,
    output logic                            mode,
    output logic                            busy,
    output logic                            gen_done,
    output logic [15:0]                     generation_count
);
    localparam int CW = $clog2(Y_SIZE + 2);
    typedef enum logic [1:0] {IDLE, FETCH, FLUSH, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [READ_LATENCY-1:0] req;
    logic [1:0] loads;
    logic win_ready, write_en, trig, last_fetch, last_flush, data_valid;
    logic [X_SIZE-1:0] top, mid, bot, next_row, result;
    logic [Y_WIDTH-1:0] write_addr, row;

    assign trig = (frame_tick & ~pause) | (step & pause);
    assign last_fetch = cnt == CW'(Y_SIZE + 1);
    assign last_flush = cnt == CW'(READ_LATENCY + 1);
    assign data_valid = req[READ_LATENCY-1];
    assign busy = state != IDLE;
    assign gen_done = state == DONE;

    // Fetch k presents row (k-1) mod Y_SIZE so the window sees the row above row 0 first.
    assign bus.line_buffer_fetch_addr = state != FETCH ? '0 :
                                        cnt == '0 ? Y_WIDTH'(Y_SIZE - 1) :
                                        last_fetch ? '0 : Y_WIDTH'(cnt - 1'b1);
    assign bus.parallel_next_state_write_addr = write_addr;
    assign bus.parallel_next_state_result = result;
    assign bus.parallel_next_state_write_en = write_en;

    always_comb begin
        state_n = state == IDLE  ? (trig ? FETCH : IDLE) :
                  state == FETCH ? (last_fetch ? FLUSH : FETCH) :
                  state == FLUSH ? (last_flush ? DONE : FLUSH) : IDLE;
        cnt_n = (state_n != state || state == IDLE) ? '0 : cnt + 1'b1;
    end

    for (genvar c = 0; c < X_SIZE; c++) begin : g_cell
        localparam logic [X_WIDTH-1:0] L = X_WIDTH'((c + X_SIZE - 1) % X_SIZE);
        localparam logic [X_WIDTH-1:0] M = X_WIDTH'(c);
        localparam logic [X_WIDTH-1:0] R = X_WIDTH'((c + 1) % X_SIZE);
        logic [3:0] n;
        assign n = 4'(top[L]) + 4'(top[M]) + 4'(top[R]) + 4'(mid[L]) + 4'(mid[R])
                 + 4'(bot[L]) + 4'(bot[M]) + 4'(bot[R]);
        assign next_row[c] = n == 4'd3 || (mid[M] && n == 4'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            req <= '0;
            loads <= '0;
            win_ready <= 1'b0;
            top <= '0;
            mid <= '0;
            bot <= '0;
            write_en <= 1'b0;
            write_addr <= '0;
            result <= '0;
            row <= '0;
            mode <= 1'b0;
            generation_count <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            // Tracks which cycles carry returned fetch data, READ_LATENCY behind the address.
            req <= READ_LATENCY'({req, state == FETCH});
            // The window is complete once two earlier rows are already loaded.
            win_ready <= data_valid && loads == 2'd2;
            if (state == IDLE)
                loads <= '0;
            else if (data_valid && loads != 2'd2)
                loads <= loads + 2'd1;
            if (data_valid)
                {top, mid, bot} <= {mid, bot, bus.line_buffer_fetch_mem};
            write_en <= win_ready;
            if (win_ready) begin
                result <= next_row;
                write_addr <= row;
                row <= row == Y_WIDTH'(Y_SIZE - 1) ? '0 : row + 1'b1;
            end
            if (state_n == DONE) begin
                mode <= ~mode;
                generation_count <= generation_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_life_generation_engine.sv
// tb_life_generation_engine: scoreboard bench for life_generation_engine with behavioural bank models.
module tb_life_generation_engine;
    localparam int X = 8;
    localparam int Y = 6;
    typedef logic [Y-1:0][X-1:0] grid_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick1 = 1'b0, tick2 = 1'b0, pause = 1'b0, step = 1'b0;
    logic pause2 = 1'b0, step2 = 1'b0;
    logic mode1, busy1, done1, mode2, busy2, done2;
    logic [15:0] cnt1, cnt2;

    life_generation_engine_if #(.X_SIZE(X), .Y_WIDTH(3)) bus1 ();
    life_generation_engine_if #(.X_SIZE(X), .Y_WIDTH(3)) bus2 ();

    life_generation_engine #(.X_SIZE(X), .Y_SIZE(Y), .X_WIDTH(3), .Y_WIDTH(3), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .frame_tick(tick1), .pause(pause), .step(step), .bus(bus1),
        .mode(mode1), .busy(busy1), .gen_done(done1), .generation_count(cnt1));
    life_generation_engine #(.X_SIZE(X), .Y_SIZE(Y), .X_WIDTH(3), .Y_WIDTH(3), .READ_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .frame_tick(tick2), .pause(pause2), .step(step2), .bus(bus2),
        .mode(mode2), .busy(busy2), .gen_done(done2), .generation_count(cnt2));

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int wr1 = 0, wr2 = 0;
    logic [10:0] q1[$], q2[$];
    grid_t m1a = '0, m1b = '0, m2a = '0, m2b = '0, ld_grid = '0;
    logic [1:0] ld_go = 2'b00;
    logic ld_bank = 1'b0;
    logic [7:0] rd2_q;
    grid_t cur[2];
    bit exp_mode[2];
    int exp_cnt[2];
    logic [2:0] fa[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bank models: ld_go preloads a whole grid; DUT writes go to the bank opposite the read bank.
    always @(posedge clk) begin
        if (ld_go[0]) begin
            if (ld_bank) m1a <= ld_grid; else m1b <= ld_grid;
        end else if (bus1.parallel_next_state_write_en) begin
            if (mode1) m1b[bus1.parallel_next_state_write_addr] <= bus1.parallel_next_state_result;
            else m1a[bus1.parallel_next_state_write_addr] <= bus1.parallel_next_state_result;
        end
        if (ld_go[1]) begin
            if (ld_bank) m2a <= ld_grid; else m2b <= ld_grid;
        end else if (bus2.parallel_next_state_write_en) begin
            if (mode2) m2b[bus2.parallel_next_state_write_addr] <= bus2.parallel_next_state_result;
            else m2a[bus2.parallel_next_state_write_addr] <= bus2.parallel_next_state_result;
        end
        bus1.line_buffer_fetch_mem <= mode1 ? m1a[bus1.line_buffer_fetch_addr] : m1b[bus1.line_buffer_fetch_addr];
        rd2_q <= mode2 ? m2a[bus2.line_buffer_fetch_addr] : m2b[bus2.line_buffer_fetch_addr];
        bus2.line_buffer_fetch_mem <= rd2_q;
    end

    always @(negedge clk) begin : mon1
        logic [10:0] e;
        if (bus1.parallel_next_state_write_en === 1'b1) begin
            wr1++;
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut1 unexpected write: row %0d data %0h, expected none",
                         bus1.parallel_next_state_write_addr, bus1.parallel_next_state_result);
            end else begin
                e = q1.pop_front();
                check("dut1 row write", {bus1.parallel_next_state_write_addr, bus1.parallel_next_state_result}, e);
            end
        end
    end

    always @(negedge clk) begin : mon2
        logic [10:0] e;
        if (bus2.parallel_next_state_write_en === 1'b1) begin
            wr2++;
            if (q2.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut2 unexpected write: row %0d data %0h, expected none",
                         bus2.parallel_next_state_write_addr, bus2.parallel_next_state_result);
            end else begin
                e = q2.pop_front();
                check("dut2 row write", {bus2.parallel_next_state_write_addr, bus2.parallel_next_state_result}, e);
            end
        end
    end

    function automatic grid_t life(input grid_t g);
        grid_t o;
        int n;
        for (int r = 0; r < Y; r++)
            for (int c = 0; c < X; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0) n += int'(g[(r + dr + Y) % Y][(c + dc + X) % X]);
                o[r][c] = (n == 3) || (g[r][c] && n == 2);
            end
        return o;
    endfunction

    function automatic logic mode_of(input int w); return w != 0 ? mode2 : mode1; endfunction
    function automatic logic busy_of(input int w); return w != 0 ? busy2 : busy1; endfunction
    function automatic logic done_of(input int w); return w != 0 ? done2 : done1; endfunction
    function automatic logic [15:0] count_of(input int w); return w != 0 ? cnt2 : cnt1; endfunction
    function automatic grid_t rbank(input int w);
        return w != 0 ? (exp_mode[w] ? m2a : m2b) : (exp_mode[w] ? m1a : m1b);
    endfunction

    task automatic set_tick(input int w, input logic v);
        if (w != 0) tick2 = v; else tick1 = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_mode[0] = 1'b0; exp_mode[1] = 1'b0;
        exp_cnt[0] = 0; exp_cnt[1] = 0;
        q1.delete(); q2.delete();
    endtask

    task automatic load(input int w, input grid_t g);
        ld_grid = g;
        ld_bank = exp_mode[w];
        ld_go = w != 0 ? 2'b10 : 2'b01;
        @(posedge clk);
        #1 ld_go = 2'b00;
        cur[w] = g;
    endtask

    task automatic push_gen(input int w);
        grid_t nx;
        nx = life(cur[w]);
        for (int r = 0; r < Y; r++)
            if (w != 0) q2.push_back({3'(r), nx[r]}); else q1.push_back({3'(r), nx[r]});
        cur[w] = nx;
    endtask

    task automatic run_gen(input int w, input int lat, input int retick, input bit tick_done, input bit use_step);
        int cyc, w0;
        push_gen(w);
        exp_mode[w] = !exp_mode[w];
        exp_cnt[w]++;
        w0 = w != 0 ? wr2 : wr1;
        if (use_step) step = 1'b1; else set_tick(w, 1'b1);
        @(posedge clk);
        #1 step = 1'b0;
        set_tick(w, 1'b0);
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            if (done_of(w)) break;
            if (cyc == 0) check("busy rises", busy_of(w), 1'b1);
            if (cyc < 8) fa[cyc] = w != 0 ? bus2.line_buffer_fetch_addr : bus1.line_buffer_fetch_addr;
            set_tick(w, cyc == retick);
            cyc++;
        end
        set_tick(w, tick_done);
        check("gen_done latency", cyc, lat);
        check("mode toggled", mode_of(w), exp_mode[w]);
        check("generation_count", count_of(w), exp_cnt[w]);
        @(posedge clk);
        #1 set_tick(w, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("idle after done", busy_of(w), 1'b0);
        end
        check("write pulses", (w != 0 ? wr2 : wr1) - w0, Y);
        check("read bank contents", rbank(w), cur[w]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        grid_t blink, blink_h, glider, glider_h, block;
        int nw;
        logic [2:0] exp_fa[8];
        exp_fa[0] = 3'd5; exp_fa[1] = 3'd0; exp_fa[2] = 3'd1; exp_fa[3] = 3'd2;
        exp_fa[4] = 3'd3; exp_fa[5] = 3'd4; exp_fa[6] = 3'd5; exp_fa[7] = 3'd0;
        blink = '0; blink[1] = 8'h08; blink[2] = 8'h08; blink[3] = 8'h08;
        blink_h = '0; blink_h[2] = 8'b0001_1100;
        glider = '0; glider[4] = 8'h80; glider[5] = 8'h01; glider[0] = 8'hC1;
        glider_h = '0; glider_h[5] = 8'h01; glider_h[0] = 8'h02; glider_h[1] = 8'h83;
        block = '0; block[2] = 8'h0C; block[3] = 8'h0C;

        do_reset();
        @(negedge clk);
        check("reset mode", mode1, 1'b0);
        check("reset busy", busy1, 1'b0);
        check("reset gen_done", done1, 1'b0);
        check("reset count", cnt1, 16'd0);
        check("reset write_en", bus1.parallel_next_state_write_en, 1'b0);
        check("reset write_addr", bus1.parallel_next_state_write_addr, 3'd0);
        check("reset result", bus1.parallel_next_state_result, 8'd0);
        check("reset fetch_addr", bus1.line_buffer_fetch_addr, 3'd0);
        @(posedge clk); #1;

        load(0, blink);
        run_gen(0, 11, -1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) check("blinker fetch addr", fa[i], exp_fa[i]);
        check("blinker result", rbank(0), blink_h);

        do_reset();
        load(0, glider);
        repeat (4) run_gen(0, 11, -1, 1'b0, 1'b0);
        check("glider shifted", rbank(0), glider_h);

        pause = 1'b1;
        repeat (2) begin
            tick1 = 1'b1;
            @(posedge clk);
            #1 tick1 = 1'b0;
            repeat (2) begin
                @(negedge clk);
                check("paused tick ignored", busy1, 1'b0);
            end
            @(posedge clk); #1;
        end
        check("paused mode stable", mode1, exp_mode[0]);
        run_gen(0, 11, -1, 1'b0, 1'b1);
        pause = 1'b0;
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("unpaused step ignored", busy1, 1'b0);
        end
        check("count after ignored step", cnt1, 16'(exp_cnt[0]));
        @(posedge clk); #1;

        run_gen(0, 11, 2, 1'b0, 1'b0);
        run_gen(0, 11, -1, 1'b1, 1'b0);

        push_gen(0);
        tick1 = 1'b1;
        @(posedge clk);
        #1 tick1 = 1'b0;
        nw = 0;
        for (int i = 0; i < 40 && nw < 4; i++) begin
            @(negedge clk);
            if (bus1.parallel_next_state_write_en === 1'b1) nw++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("writes before reset", nw, 4);
        check("reset mid-op write_en", bus1.parallel_next_state_write_en, 1'b0);
        check("reset mid-op mode", mode1, 1'b0);
        check("reset mid-op count", cnt1, 16'd0);
        check("reset mid-op busy", busy1, 1'b0);
        q1.delete();
        exp_mode[0] = 1'b0;
        exp_cnt[0] = 0;
        @(posedge clk); #1;
        load(0, blink);
        run_gen(0, 11, -1, 1'b0, 1'b0);
        check("post-reset blinker", rbank(0), blink_h);

        load(1, block);
        run_gen(1, 12, -1, 1'b0, 1'b0);
        check("still life gen 1", rbank(1), block);
        run_gen(1, 12, -1, 1'b0, 1'b0);
        check("still life gen 2", rbank(1), block);

        check("dut1 queue drained", q1.size(), 0);
        check("dut2 queue drained", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
